// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the pixel request arbiter.
//   arb_state_t : arbiter FSM state encoding (IDLE, ADDR, ACK, RELEASE)
//   pick_t      : result of a winner search (found flag + channel index)
//   rr_pick()   : rotating first-set-bit search used for both round-robin
//                 (origin = pointer) and fixed priority (origin = 0)
// -----------------------------------------------------------------------------
package arb_pkg;

    // Widest supported arbiter; the picker always works on this width and the
    // top zero-extends its request vector into it.
    localparam int MAX_CH = 64;
    localparam int IDX_W  = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR    = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit at index >= ptr, wrapping through n-1 back to 0.
    // Only the lowest n bits of req are meaningful; ptr must be below n.
    function automatic pick_t rr_pick(
        input logic [MAX_CH-1:0] req,
        input logic [IDX_W-1:0]  ptr,
        input int                n
    );
        pick_t            res;
        int               j;
        logic [IDX_W-1:0] jj;
        res.found = 1'b0;
        res.idx   = {IDX_W{1'b0}};
        for (int i = 0; i < MAX_CH; i++) begin
            j  = int'(ptr) + i;
            // ptr < n and i < n, so one subtraction is enough to wrap.
            j  = (j >= n) ? (j - n) : j;
            jj = j[IDX_W-1:0];
            if ((i < n) && !res.found && req[jj]) begin
                res.found = 1'b1;
                res.idx   = jj;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pixel_rr_arbiter_req_sync.sv
// -----------------------------------------------------------------------------
// req_sync
// Per-bit multi-flop synchroniser for the asynchronous pixel request lines,
// with a synchronous clear so a reset also flushes requests in flight.
// STAGES = 0 turns it into a wire for already-synchronous sources.
// Ports:
//   clk : sampling clock
//   rst : synchronous active-high clear of every stage
//   d   : raw request vector
//   q   : request vector after STAGES flops
// -----------------------------------------------------------------------------
module req_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (STAGES == 0) begin : g_bypass
        logic unused_s;
        assign unused_s = clk ^ rst;
        assign q        = d;
    end else begin : g_sync
        logic [WIDTH-1:0] stage_r [STAGES];

        // Shift each request bit through the synchroniser chain.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < STAGES; i++) begin
                    stage_r[i] <= {WIDTH{1'b0}};
                end
            end else begin
                stage_r[0] <= d;
                for (int i = 1; i < STAGES; i++) begin
                    stage_r[i] <= stage_r[i-1];
                end
            end
        end

        assign q = stage_r[STAGES-1];
    end

endmodule

// File: rtl/pixel_rr_arbiter.sv
// -----------------------------------------------------------------------------
// pixel_rr_arbiter
// N-channel arbiter for level-sensitive four-phase pixel hit requests.
// The winner's channel index is offered to the column readout over a
// valid/ready handshake; once accepted, the winning pixel gets its ack and
// the four-phase handshake is completed before the next grant.
// Ports:
//   clk       : single clock
//   rst       : synchronous active-high reset (aborts any transaction)
//   req       : per-pixel request level, held until ack is seen
//   ack       : per-pixel acknowledge, one-hot or zero
//   out_valid : winner address available to the readout
//   out_ready : readout accepts the address
//   out_addr  : index of the granted channel
//   busy      : high whenever the arbiter is not in IDLE
// -----------------------------------------------------------------------------
module pixel_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N_CH        = 8,
    parameter int ADDR_W      = (N_CH > 2) ? $clog2(N_CH) : 1,
    parameter int SYNC_STAGES = 2,
    parameter int RR_MODE     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   req,
    output logic [N_CH-1:0]   ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy
);

    localparam logic [N_CH-1:0]   ACK_ONE  = N_CH'(1);
    localparam logic [ADDR_W-1:0] LAST_CH  = ADDR_W'(N_CH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [N_CH-1:0]   req_s;
    logic [MAX_CH-1:0] req_ext_s;
    logic [IDX_W-1:0]  ptr_ext_s;
    pick_t             pick_s;
    logic [ADDR_W-1:0] pick_idx_s;
    logic [ADDR_W-1:0] ptr_next_s;
    logic [ADDR_W-1:0] ptr_r;
    arb_state_t        state_r;
    logic              unused_s;

    req_sync #(
        .WIDTH  (N_CH),
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (req),
        .q   (req_s)
    );

    // Widen the synchronised requests to the picker's fixed width.
    always_comb begin
        req_ext_s              = {MAX_CH{1'b0}};
        req_ext_s[N_CH-1:0]    = req_s;
    end

    // Scan origin: the rotating pointer in round-robin, channel 0 otherwise.
    always_comb begin
        ptr_ext_s = {IDX_W{1'b0}};
        if (RR_MODE != 0) begin
            ptr_ext_s[ADDR_W-1:0] = ptr_r;
        end else begin
            ptr_ext_s = {IDX_W{1'b0}};
        end
    end

    assign pick_s     = rr_pick(req_ext_s, ptr_ext_s, N_CH);
    assign pick_idx_s = pick_s.idx[ADDR_W-1:0];

    // out_addr holds the current winner for the whole transaction, so the
    // pointer successor is derived from it directly.
    assign ptr_next_s = (out_addr == LAST_CH) ? {ADDR_W{1'b0}} : (out_addr + ADDR_ONE);

    // Upper picker bits are always zero for N_CH < 64; the pointer is
    // irrelevant in fixed-priority mode.
    assign unused_s = ^{pick_s.idx, ptr_r};

    // Arbiter FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            ack       <= {N_CH{1'b0}};
            out_valid <= 1'b0;
            out_addr  <= {ADDR_W{1'b0}};
            busy      <= 1'b0;
            ptr_r     <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    // Requests that arrived while busy are seen here first.
                    if (pick_s.found) begin
                        out_addr  <= pick_idx_s;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state_r   <= ADDR;
                    end else begin
                        busy      <= 1'b0;
                    end
                end
                ADDR: begin
                    // The address is delivered even if the pixel withdrew
                    // its request; ACK will then exit on its first cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ack       <= ACK_ONE << out_addr;
                        state_r   <= ACK;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                ACK: begin
                    if (!req_s[out_addr]) begin
                        ack     <= {N_CH{1'b0}};
                        state_r <= RELEASE;
                    end else begin
                        state_r <= ACK;
                    end
                end
                RELEASE: begin
                    // One quiet cycle keeps ack low before any new grant.
                    if (RR_MODE != 0) begin
                        ptr_r <= ptr_next_s;
                    end else begin
                        ptr_r <= {ADDR_W{1'b0}};
                    end
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    ack       <= {N_CH{1'b0}};
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pixel_rr_arbiter
// Two instances: index 0 is round-robin with a 2-flop synchroniser, index 1
// is fixed priority with synchronous inputs. Pixel agents run the four-phase
// protocol from per-channel request budgets; the main thread pushes expected
// grant addresses from a behavioural model, and a monitor pops and compares
// them on every accepted address transfer.
// -----------------------------------------------------------------------------
module tb_pixel_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req_v   [2];
    logic [7:0] ack_v   [2];
    logic       ov_v    [2];
    logic       rdy_v   [2];
    logic [2:0] addr_v  [2];
    logic       busy_v  [2];

    int   n_chk;
    int   n_fail;
    int   exp_q    [2][$];
    int   bud      [2][8];
    int   done_cnt [2][8];
    int   dly      [2][8];
    logic hold     [2][8];
    logic rnd_en;
    int   mptr;
    logic       pend      [2];
    logic [2:0] pend_addr [2];

    pixel_rr_arbiter #(.N_CH(8), .SYNC_STAGES(2), .RR_MODE(1)) dut (
        .clk(clk), .rst(rst), .req(req_v[0]), .ack(ack_v[0]),
        .out_valid(ov_v[0]), .out_ready(rdy_v[0]), .out_addr(addr_v[0]), .busy(busy_v[0])
    );

    pixel_rr_arbiter #(.N_CH(8), .SYNC_STAGES(0), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst(rst), .req(req_v[1]), .ack(ack_v[1]),
        .out_valid(ov_v[1]), .out_ready(rdy_v[1]), .out_addr(addr_v[1]), .busy(busy_v[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // Round-robin reference: serve every channel in m, each time taking the
    // first requester at or after the pointer, then moving past the winner.
    function automatic void model_rr(input logic [7:0] m);
        logic [7:0] s;
        s = m;
        while (s != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (mptr + k) % 8;
                if (s[c]) begin
                    exp_q[0].push_back(c);
                    s[c] = 1'b0;
                    mptr = (c + 1) % 8;
                    break;
                end
            end
        end
    endfunction

    function automatic bit is_idle(input int d);
        bit r;
        r = (req_v[d] == 8'h00) && (ack_v[d] == 8'h00) && !busy_v[d] && !ov_v[d];
        for (int i = 0; i < 8; i++) begin
            if (done_cnt[d][i] < bud[d][i]) r = 1'b0;
        end
        return r;
    endfunction

    task automatic wait_idle(input int d);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 800 && !ok; c++) begin
            @(posedge clk); #1;
            ok = is_idle(d);
        end
        chk("idle_reached", d, 64'(ok), 64'd1);
        chk("queue_drained", d, 64'(exp_q[d].size()), 64'd0);
    endtask

    // Pixel agents: raise when budget remains and ack is low, drop after ack.
    initial begin
        for (int d = 0; d < 2; d++) begin
            req_v[d] = 8'h00;
            for (int i = 0; i < 8; i++) begin
                done_cnt[d][i] = 0;
                dly[d][i]      = 0;
            end
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 8; i++) begin
                    if (req_v[d][i]) begin
                        if (ack_v[d][i] && !hold[d][i]) begin
                            if (dly[d][i] > 0) begin
                                dly[d][i]--;
                            end else begin
                                req_v[d][i] = 1'b0;
                                done_cnt[d][i]++;
                            end
                        end
                    end else if (!ack_v[d][i] && (done_cnt[d][i] < bud[d][i])) begin
                        req_v[d][i] = 1'b1;
                        dly[d][i]   = rnd_en ? int'($urandom_range(0, 3)) : 0;
                    end
                end
            end
        end
    end

    // Monitor: invariants every cycle, grant address on every transfer,
    // and ack of the winner exactly one cycle after the transfer.
    initial begin
        int e;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    pend[d] = 1'b0;
                end else begin
                    chk("ack_onehot0", d, 64'($onehot0(ack_v[d])), 64'd1);
                    chk("ack_with_valid", d, 64'((|ack_v[d]) && ov_v[d]), 64'd0);
                    if (pend[d]) begin
                        chk("ack_after_accept", d, 64'(ack_v[d]), 64'(8'b1 << pend_addr[d]));
                        pend[d] = 1'b0;
                    end
                    if (ov_v[d] && rdy_v[d]) begin
                        if (exp_q[d].size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL spurious_grant dut%0d: got addr %0d, expected no grant", d, addr_v[d]);
                        end else begin
                            e = exp_q[d].pop_front();
                            chk("grant_addr", d, 64'(addr_v[d]), 64'(e));
                        end
                        pend[d]      = 1'b1;
                        pend_addr[d] = addr_v[d];
                    end
                end
            end
        end
    end

    initial begin
        bit         seen;
        logic [7:0] mask;
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        rnd_en = 1'b0;
        mptr   = 0;
        for (int d = 0; d < 2; d++) begin
            rdy_v[d] = 1'b1;
            for (int i = 0; i < 8; i++) begin
                bud[d][i]  = 0;
                hold[d][i] = 1'b0;
            end
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ack", d, 64'(ack_v[d]), 64'd0);
            chk("rst_valid", d, 64'(ov_v[d]), 64'd0);
            chk("rst_addr", d, 64'(addr_v[d]), 64'd0);
            chk("rst_busy", d, 64'(busy_v[d]), 64'd0);
        end
        rst = 1'b0;

        // Single request on channel 3: latency and release timing
        @(posedge clk); #1;
        model_rr(8'h08);
        bud[0][3]++;
        repeat (2) @(posedge clk);
        #1;
        chk("valid_not_early", 0, 64'(ov_v[0]), 64'd0);
        @(posedge clk); #1;
        chk("valid_at_sync_plus1", 0, 64'(ov_v[0]), 64'd1);
        chk("addr_ch3", 0, 64'(addr_v[0]), 64'd3);
        chk("busy_in_addr", 0, 64'(busy_v[0]), 64'd1);
        @(posedge clk); #1;
        chk("ack_ch3", 0, 64'(ack_v[0]), 64'h08);
        chk("valid_dropped", 0, 64'(ov_v[0]), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("ack_held_during_sync", 0, 64'(ack_v[0]), 64'h08);
        @(posedge clk); #1;
        chk("ack_released", 0, 64'(ack_v[0]), 64'd0);
        chk("busy_in_release", 0, 64'(busy_v[0]), 64'd1);
        @(posedge clk); #1;
        chk("busy_cleared", 0, 64'(busy_v[0]), 64'd0);
        wait_idle(0);

        // Readout stalls for 10 cycles with channel 5 pending
        rdy_v[0] = 1'b0;
        model_rr(8'h20);
        bud[0][5]++;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk); #1;
            seen = ov_v[0];
        end
        chk("stall_valid_seen", 0, 64'(seen), 64'd1);
        for (int k = 0; k < 10; k++) begin
            chk("stall_valid", 0, 64'(ov_v[0]), 64'd1);
            chk("stall_addr", 0, 64'(addr_v[0]), 64'd5);
            chk("stall_no_ack", 0, 64'(ack_v[0]), 64'd0);
            @(posedge clk); #1;
        end
        rdy_v[0] = 1'b1;
        @(posedge clk); #1;
        chk("ack_after_ready", 0, 64'(ack_v[0]), 64'h20);
        wait_idle(0);

        // Reset while channel 2 is in ACK, then a normal re-grant
        hold[0][2] = 1'b1;
        model_rr(8'h04);
        bud[0][2]++;
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(posedge clk); #1;
            seen = ack_v[0][2];
        end
        chk("ack2_seen", 0, 64'(seen), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ack", 0, 64'(ack_v[0]), 64'd0);
        chk("midrst_valid", 0, 64'(ov_v[0]), 64'd0);
        chk("midrst_busy", 0, 64'(busy_v[0]), 64'd0);
        rst  = 1'b0;
        mptr = 0;
        model_rr(8'h04);
        seen = 1'b0;
        for (int c = 0; c < 30 && !seen; c++) begin
            @(posedge clk); #1;
            seen = ack_v[0][2];
        end
        chk("ack2_regrant", 0, 64'(seen), 64'd1);
        hold[0][2] = 1'b0;
        wait_idle(0);

        // Pointer wrap: grant 6 leaves ptr at 7, then 7 and 0 together
        model_rr(8'h40);
        bud[0][6]++;
        wait_idle(0);
        model_rr(8'h81);
        bud[0][7]++;
        bud[0][0]++;
        wait_idle(0);

        // All channels requesting, channel 0 twice: RR order 0..7,0
        rst = 1'b1;
        @(posedge clk); #1;
        rst  = 1'b0;
        for (int i = 0; i < 8; i++) exp_q[0].push_back(i);
        exp_q[0].push_back(0);
        mptr = 1;
        for (int i = 0; i < 8; i++) bud[0][i]++;
        bud[0][0]++;
        wait_idle(0);

        // Randomised rounds: random request sets and readout back-pressure
        rnd_en = 1'b1;
        for (int r = 0; r < 15; r++) begin
            mask = 8'($urandom_range(1, 255));
            model_rr(mask);
            for (int i = 0; i < 8; i++) begin
                if (mask[i]) bud[0][i]++;
            end
            seen = 1'b0;
            for (int c = 0; c < 800 && !seen; c++) begin
                @(posedge clk); #1;
                rdy_v[0] = 1'($urandom_range(0, 1));
                seen     = is_idle(0);
            end
            rdy_v[0] = 1'b1;
            chk("rand_round_done", 0, 64'(seen), 64'd1);
            chk("rand_queue_drained", 0, 64'(exp_q[0].size()), 64'd0);
        end
        rnd_en = 1'b0;

        // Fixed priority: channel 0 re-requesting starves the others
        for (int k = 0; k < 4; k++) exp_q[1].push_back(0);
        for (int i = 1; i < 8; i++) exp_q[1].push_back(i);
        bud[1][0] += 4;
        for (int i = 1; i < 8; i++) bud[1][i]++;
        wait_idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
